// File: rtl/node_pkg.sv
// Shared types and helpers for the sequential neuron MAC (node_mac_seq).
package node_pkg;
  localparam int              FP_W    = 32;
  localparam logic [FP_W-1:0] FP_ZERO = '0;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  // Negative (including -0.0) maps to +0.0.
  function automatic logic [FP_W-1:0] relu(input logic [FP_W-1:0] x);
    return x[FP_W-1] ? FP_ZERO : x;
  endfunction
endpackage

// File: rtl/node_mac_seq_mac.sv
// Shared FP32 datapath: one multiplier, one adder, product register and accumulator.
// Zeros/denormals flush to zero, round-to-nearest-even, overflow saturates to infinity.
import node_pkg::*;

module float_mult (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);
  logic [47:0]       w_p;
  logic signed [9:0] w_e;
  logic [22:0]       w_m;
  logic              w_g, w_st, w_inc;
  logic [24:0]       w_r;

  always_comb begin
    w_p = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
    w_e = $signed({2'b00, i_a[30:23]}) + $signed({2'b00, i_b[30:23]}) - 10'sd127;
    if (w_p[47]) begin
      w_m = w_p[46:24]; w_g = w_p[23]; w_st = |w_p[22:0]; w_e = w_e + 10'sd1;
    end else begin
      w_m = w_p[45:23]; w_g = w_p[22]; w_st = |w_p[21:0];
    end
    w_inc = w_g & (w_st | w_m[0]);
    w_r   = {2'b01, w_m} + {24'd0, w_inc};
    if (w_r[24]) w_e = w_e + 10'sd1;
    o_p = {i_a[31] ^ i_b[31], w_e[7:0], w_r[24] ? w_r[23:1] : w_r[22:0]};
    if (i_a[30:23] == 8'd0 || i_b[30:23] == 8'd0 || w_e <= 10'sd0)
      o_p = {i_a[31] ^ i_b[31], 31'd0};
    else if (w_e >= 10'sd255)
      o_p = {i_a[31] ^ i_b[31], 8'hFF, 23'd0};
  end
endmodule

module float_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_s
);
  function automatic logic [4:0] lzc27(input logic [26:0] x);
    logic [4:0] r;
    r = 5'd27;
    for (int i = 0; i < 27; i++) if (x[i]) r = 5'(26 - i);
    return r;
  endfunction

  logic [31:0]       w_big, w_sml;
  logic [7:0]        w_d;
  logic [26:0]       w_mb, w_ms, w_sh, w_m;
  logic [27:0]       w_s;
  logic              w_st, w_inc;
  logic [4:0]        w_lz;
  logic signed [9:0] w_e;
  logic [24:0]       w_r;

  always_comb begin
    if (i_b[30:0] > i_a[30:0]) begin w_big = i_b; w_sml = i_a; end
    else                       begin w_big = i_a; w_sml = i_b; end
    w_d  = w_big[30:23] - w_sml[30:23];
    w_mb = {1'b1, w_big[22:0], 3'b000};
    w_ms = {1'b1, w_sml[22:0], 3'b000};
    // Align the smaller operand; any bit shifted out folds into the sticky LSB.
    w_sh    = w_ms >> w_d;
    w_st    = (w_sh << w_d) != w_ms;
    w_sh[0] = w_sh[0] | w_st;
    w_e  = $signed({2'b00, w_big[30:23]});
    w_lz = '0;
    if (w_big[31] == w_sml[31]) begin
      w_s = {1'b0, w_mb} + {1'b0, w_sh};
      if (w_s[27]) begin
        w_m = {w_s[27:2], w_s[1] | w_s[0]};
        w_e = w_e + 10'sd1;
      end else begin
        w_m = w_s[26:0];
      end
    end else begin
      w_s  = {1'b0, w_mb} - {1'b0, w_sh};
      w_lz = lzc27(w_s[26:0]);
      w_m  = w_s[26:0] << w_lz;
      w_e  = w_e - $signed({5'd0, w_lz});
    end
    w_inc = w_m[2] & (w_m[1] | w_m[0] | w_m[3]);
    w_r   = {1'b0, w_m[26:3]} + {24'd0, w_inc};
    if (w_r[24]) w_e = w_e + 10'sd1;
    o_s = {w_big[31], w_e[7:0], w_r[24] ? w_r[23:1] : w_r[22:0]};
    if (w_sml[30:23] == 8'd0)                o_s = w_big;
    else if (w_m == 27'd0 || w_e <= 10'sd0)  o_s = 32'd0;
    else if (w_e >= 10'sd255)                o_s = {w_big[31], 8'hFF, 23'd0};
  end
endmodule

module fp_mac_unit (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_load,
  input  logic [FP_W-1:0] i_bias,
  input  logic            i_mul_en,
  input  logic [FP_W-1:0] i_act,
  input  logic [FP_W-1:0] i_w,
  input  logic            i_acc_en,
  output logic [FP_W-1:0] o_acc
);
  logic [FP_W-1:0] r_prod, r_acc, w_prod, w_sum;

  float_mult  u_mul (.i_a(i_w),   .i_b(i_act),  .o_p(w_prod));
  float_adder u_add (.i_a(r_acc), .i_b(r_prod), .o_s(w_sum));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prod <= FP_ZERO;
      r_acc  <= FP_ZERO;
    end else begin
      if (i_mul_en) r_prod <= w_prod;
      if (i_load)        r_acc <= i_bias;
      else if (i_acc_en) r_acc <= w_sum;
    end
  end

  assign o_acc = r_acc;
endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed neuron: out = bias + sum(w_i * a_i), one pair per cycle, strictly sequential.
// Optional NODE_RELU_EN: clamp negative results (and -0.0) to +0.0.
import node_pkg::*;

module node_mac_seq #(
  parameter int N_IN = 30
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [FP_W-1:0] i_bias,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [FP_W-1:0] i_in_act,
  input  logic [FP_W-1:0] i_in_w,
  input  logic            i_in_last,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [FP_W-1:0] o_out_data,
  output logic            o_out_err
);
  localparam int CW = $clog2(N_IN + 1);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_in_hs, w_out_hs, w_full, w_term;
  logic            r_prod_vld, r_err;
  logic            r_out_valid, r_out_err;
  logic [FP_W-1:0] r_out_data, w_acc, w_res;

  assign w_in_hs   = i_in_valid & o_in_ready;
  assign w_out_hs  = r_out_valid & i_out_ready;
  assign w_cnt_nxt = (r_state == IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_full    = (w_cnt_nxt == CW'(N_IN));
  assign w_term    = w_in_hs & (i_in_last | w_full);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_in_hs) w_state_nxt = w_term ? DRAIN : ACCUM;
      ACCUM:   if (w_term)  w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = OUT;
      OUT:     if (w_out_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_in_ready = (r_state == IDLE) || (r_state == ACCUM);
  end

  fp_mac_unit u_mac (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_in_hs && r_state == IDLE),
    .i_bias   (i_bias),
    .i_mul_en (w_in_hs),
    .i_act    (i_in_act),
    .i_w      (i_in_w),
    .i_acc_en (r_prod_vld),
    .o_acc    (w_acc)
  );

`ifdef NODE_RELU_EN
  assign w_res = relu(w_acc);
`else
  assign w_res = w_acc;
`endif

  // OUT spends its first cycle capturing the settled accumulator, so out_valid
  // rises two cycles after the last input handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_prod_vld  <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= FP_ZERO;
      r_out_err   <= 1'b0;
    end else begin
      r_prod_vld <= w_in_hs;
      if (w_in_hs) r_cnt <= w_cnt_nxt;
      if (w_term)  r_err <= i_in_last ^ w_full;
      if (r_state == OUT && !r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
        r_out_err   <= r_err;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_err   = r_out_err;
endmodule

// File: tb/tb_node_mac_seq.sv
// Scoreboard bench for node_mac_seq: two instances (N_IN=4 and N_IN=30) on shared input buses.
module tb_node_mac_seq;
  typedef struct { logic [31:0] d; logic e; } exp_t;

  localparam logic [31:0] F_ONE  = 32'h3F800000;
  localparam logic [31:0] F_HALF = 32'h3F000000;
  localparam logic [31:0] F_M1   = 32'hBF800000;
  localparam logic [31:0] F_TWO  = 32'h40000000;
  localparam logic [31:0] F_1P5  = 32'h3FC00000;

  logic        clk, rst_n;
  logic [31:0] bias, act, wt;
  logic        last_i, out_ready, v4, v30;
  logic        rdy4, rdy30, ov4, ov30, oe4, oe30;
  logic [31:0] od4, od30;

  int   n_chk = 0, n_fail = 0;
  exp_t q4[$], q30[$];

  node_mac_seq #(.N_IN(4)) u_d4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bias(bias), .i_in_valid(v4), .o_in_ready(rdy4),
    .i_in_act(act), .i_in_w(wt), .i_in_last(last_i), .o_out_valid(ov4),
    .i_out_ready(out_ready), .o_out_data(od4), .o_out_err(oe4));

  node_mac_seq #(.N_IN(30)) u_d30 (
    .i_clk(clk), .i_rst_n(rst_n), .i_bias(bias), .i_in_valid(v30), .o_in_ready(rdy30),
    .i_in_act(act), .i_in_w(wt), .i_in_last(last_i), .o_out_valid(ov30),
    .i_out_ready(out_ready), .o_out_data(od30), .o_out_err(oe30));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
    end
  endtask

  function automatic logic [31:0] f2b(input real x);
    real m; int e; logic s; longint f;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0); m = s ? -x : x; e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = longint'((m - 1.0) * 8388608.0);
    return {s, 8'(e), 23'(f)};
  endfunction

  function automatic logic [31:0] out_fn(input logic [31:0] x);
`ifdef NODE_RELU_EN
    return x[31] ? 32'd0 : x;
`else
    return x;
`endif
  endfunction

  // Monitors: pop and compare whenever a result handshake is about to happen.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov4 && out_ready) begin
      if (q4.size() == 0) begin
        n_chk++; n_fail++; $display("FAIL d4 unexpected output: got %h expected none", od4);
      end else begin
        e = q4.pop_front();
        chk("d4 out_data", od4, e.d);
        chk("d4 out_err", {31'd0, oe4}, {31'd0, e.e});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ov30 && out_ready) begin
      if (q30.size() == 0) begin
        n_chk++; n_fail++; $display("FAIL d30 unexpected output: got %h expected none", od30);
      end else begin
        e = q30.pop_front();
        chk("d30 out_data", od30, e.d);
        chk("d30 out_err", {31'd0, oe30}, {31'd0, e.e});
      end
    end
  end

  // Present one pair to the selected instance; returns 1ns after the handshake edge.
  task automatic send(input int sel, input logic [31:0] b, input logic [31:0] a,
                      input logic [31:0] w, input logic l);
    int  t = 0;
    logic hs = 1'b0;
    bias = b; act = a; wt = w; last_i = l;
    if (sel == 4) v4 = 1'b1; else v30 = 1'b1;
    while (!hs && t < 200) begin
      @(negedge clk); hs = (sel == 4) ? rdy4 : rdy30;
      @(posedge clk); #1; t++;
    end
    v4 = 1'b0; v30 = 1'b0; last_i = 1'b0;
    if (!hs) begin n_chk++; n_fail++; $display("FAIL send timeout: got no in_ready expected handshake"); end
  endtask

  task automatic frame(input int sel, input logic [31:0] b, input logic [31:0] a,
                       input logic [31:0] w, input int n, input int last_at);
    for (int i = 0; i < n; i++) send(sel, b, a, w, i == last_at);
  endtask

  task automatic wait_ov(input int sel);
    int t = 0;
    do begin @(negedge clk); t++; end while (!((sel == 4) ? ov4 : ov30) && t < 100);
    if (t >= 100) begin n_chk++; n_fail++; $display("FAIL wait out_valid: got 0 expected 1"); end
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Random-gap frame on the 30-pair instance against a sequential real-valued model.
  task automatic gap_frame(input real b);
    real acc_m, a_r, w_r;
    acc_m = b;
    for (int i = 0; i < 30; i++) acc_m = acc_m + ((i + 1) * 0.25) * (((i % 7) - 3) * 0.5);
    q30.push_back('{out_fn(f2b(acc_m)), 1'b0});
    for (int i = 0; i < 30; i++) begin
      a_r = (i + 1) * 0.25;
      w_r = ((i % 7) - 3) * 0.5;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      send(30, f2b(b), f2b(a_r), f2b(w_r), i == 29);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; v4 = 0; v30 = 0; last_i = 0; out_ready = 1'b1;
    bias = '0; act = '0; wt = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset out_valid", {31'd0, ov4}, 32'd0);
    chk("reset out_data", od4, 32'd0);
    chk("reset in_ready", {31'd0, rdy4}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 4 x (1.0 * 0.5) + 0 = 2.0, with latency probes
    q4.push_back('{32'h40000000, 1'b0});
    frame(4, 32'h0, F_ONE, F_HALF, 4, 3);
    @(negedge clk);
    chk("t1 in_ready low after last", {31'd0, rdy4}, 32'd0);
    chk("t1 out_valid at t+0", {31'd0, ov4}, 32'd0);
    @(negedge clk);
    chk("t1 out_valid at t+1", {31'd0, ov4}, 32'd0);
    @(negedge clk);
    chk("t1 out_valid at t+2", {31'd0, ov4}, 32'd1);
    settle();

    // 0.5 + 4 x (1.0 * -1.0) = -3.5
    q4.push_back('{out_fn(32'hC0600000), 1'b0});
    frame(4, F_HALF, F_ONE, F_M1, 4, 3);
    settle();

    // Backpressure: 1 + 4 x (2.0 * 1.5) = 13.0 held while out_ready is low
    out_ready = 1'b0;
    q4.push_back('{32'h41500000, 1'b0});
    frame(4, F_ONE, F_TWO, F_1P5, 4, 3);
    wait_ov(4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall out_valid", {31'd0, ov4}, 32'd1);
      chk("stall out_data", od4, 32'h41500000);
      chk("stall in_ready", {31'd0, rdy4}, 32'd0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post-accept out_valid", {31'd0, ov4}, 32'd0);
    chk("post-accept in_ready", {31'd0, rdy4}, 32'd1);
    settle();

    // Early in_last on the 2nd pair: 2 x (2.0 * 1.0) = 4.0, error; next frame clean
    q4.push_back('{32'h40800000, 1'b1});
    frame(4, 32'h0, F_TWO, F_ONE, 2, 1);
    q4.push_back('{32'h40000000, 1'b0});
    frame(4, 32'h0, F_ONE, F_HALF, 4, 3);
    settle();

    // 4th pair without in_last closes the frame with an error; following pairs start a new frame
    q4.push_back('{32'h40000000, 1'b1});
    frame(4, 32'h0, F_ONE, F_HALF, 4, -1);
    q4.push_back('{32'h41000000, 1'b0});
    frame(4, 32'h0, F_TWO, F_ONE, 4, 3);
    settle();

    // 30-pair frame with random in_valid gaps
    gap_frame(-1.5);
    settle();

    // Short frame on the 30-pair instance leaves out_data/out_err nonzero before reset
    q30.push_back('{32'h40400000, 1'b1});
    frame(30, 32'h0, F_ONE, F_ONE, 3, 2);
    settle();

    // Asynchronous reset in the middle of a 30-pair frame
    frame(30, F_ONE, F_TWO, F_TWO, 10, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst out_data d30", od30, 32'd0);
    chk("async rst out_err d30", {31'd0, oe30}, 32'd0);
    chk("async rst out_valid d30", {31'd0, ov30}, 32'd0);
    chk("async rst in_ready d30", {31'd0, rdy30}, 32'd1);
    chk("async rst out_data d4", od4, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    gap_frame(2.25);
    settle();

    chk("d4 scoreboard drained", q4.size(), 32'd0);
    chk("d30 scoreboard drained", q30.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
